// File: rtl/soc_irq_pkg.sv
// soc_irq_pkg: register map constants and priority encoder for soc_irq_ctrl.
package soc_irq_pkg;
   localparam logic [7:0] IRQ_OFF_RAW     = 8'h00;
   localparam logic [7:0] IRQ_OFF_PENDING = 8'h04;
   localparam logic [7:0] IRQ_OFF_ENABLE  = 8'h08;
   localparam logic [7:0] IRQ_OFF_MODE    = 8'h0C;
   localparam logic [7:0] IRQ_OFF_VECTOR  = 8'h10;
   localparam logic [7:0] IRQ_OFF_SWSET   = 8'h14;
   localparam int IRQ_VEC_VALID_BIT = 31;
   localparam int IRQ_MAX_SRC = 32;

   // Lowest set index wins; an empty vector encodes as 0.
   function automatic logic [4:0] irq_prio_enc(input logic [31:0] v);
      logic [4:0] id;
      id = '0;
      for (int i = IRQ_MAX_SRC - 1; i >= 0; i--)
         if (v[i]) id = 5'(i);
      return id;
   endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: parametrised-width 2-flop synchronizer, async active-low reset.
module irq_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk or negedge rst)
      if (!rst) {q, meta} <= '0;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/soc_irq_ctrl.sv
// soc_irq_ctrl: memory-mapped interrupt controller with enable, edge/level mode, W1C pending and SWSET.
// Define SOC_IRQ_SYNC_EN to pass sources through a 2-flop synchronizer.
module soc_irq_ctrl
   import soc_irq_pkg::*;
#(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0F00
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src,
   input  logic               we,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               irq,
   output logic [4:0]         irq_id
);
   logic [NUM_SRC-1:0] s_in, s, pend, en, mode, swl;
   logic [NUM_SRC-1:0] w1c, sws, rise, en_d, mode_d, swl_d, pend_d, wd, active;
   logic hit, wr, unused_wdata;
   logic [7:0] off;
   logic [31:0] vec;

`ifdef SOC_IRQ_SYNC_EN
   irq_sync #(.W(NUM_SRC)) u_sync (.clk(clk), .rst(rst), .d(src), .q(s_in));
`else
   assign s_in = src;
`endif

   assign hit = addr[31:8] == BASE_ADDR[31:8];
   assign off = addr[7:0];
   assign wr = we & hit;
   assign wd = wdata[NUM_SRC-1:0];
   assign unused_wdata = ^wdata;

   // s holds the previous sample, so s_in & ~s is the rising edge seen at this clock.
   always_comb begin
      w1c = (wr && off == IRQ_OFF_PENDING) ? wd : '0;
      sws = (wr && off == IRQ_OFF_SWSET) ? wd : '0;
      en_d = (wr && off == IRQ_OFF_ENABLE) ? wd : en;
      mode_d = (wr && off == IRQ_OFF_MODE) ? wd : mode;
      rise = s_in & ~s;
      swl_d = ~mode_d & ((swl & ~w1c) | sws);
      pend_d = (mode & mode_d & ((pend & ~w1c) | rise | sws)) | (~mode_d & (s_in | swl_d));
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) {s, pend, en, mode, swl} <= '0;
      else {s, pend, en, mode, swl} <= {s_in, pend_d, en_d, mode_d, swl_d};

   assign active = pend & en;
   assign irq = |active;
   assign irq_id = irq_prio_enc(32'(active));

   always_comb begin
      vec = 32'(irq_id);
      vec[IRQ_VEC_VALID_BIT] = irq;
      rdata = !hit ? '0 :
              off == IRQ_OFF_RAW     ? 32'(s) :
              off == IRQ_OFF_PENDING ? 32'(pend) :
              off == IRQ_OFF_ENABLE  ? 32'(en) :
              off == IRQ_OFF_MODE    ? 32'(mode) :
              off == IRQ_OFF_VECTOR  ? vec : '0;
   end
endmodule
